// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    START,
    BITS,
    WAIT_IDLE,
    ERR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // bit_cnt value once the stop bit is on the line; the next edge is the ACK.
  localparam logic [3:0] PS2_LAST_BIT = 4'd9;

  // {stop, odd parity, data}; the start bit is driven separately.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a clock
// falling-edge detector; usable by both the transmitter and the receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_async,
  input  logic data_async,
  output logic clk_sync,
  output logic data_sync,
  output logic fe
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Idle lines are high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= clk_async;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= data_async;
      data_p1 <= data_p0;
    end
  end

  assign clk_sync  = clk_p1;
  assign data_sync = data_p1;
  assign fe        = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shifts
// the frame on device clock falling edges, checks the ACK and waits for idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned REQ_CYCLES     = 100,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned FRAME_TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAX_B   = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  ps2_tx_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [9:0]       shift, shift_nxt;
  logic             data_oe_r, data_oe_nxt;
  logic             clk_sync, data_sync, fe;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .clk_async  (ps2_clk_async),
    .data_async (ps2_data_async),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .fe         (fe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Frame payload only matters inside START/BITS, so it carries no reset.
  always_ff @(posedge clk) begin
    shift     <= shift_nxt;
    data_oe_r <= data_oe_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_oe_nxt = data_oe_r;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        cnt_nxt  = '0;
        if (tx_valid) begin
          shift_nxt = ps2_frame(tx_data);
          state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        ps2_data_oe = 1'b1;
        // An edge arriving on the timeout cycle still wins.
        if (fe) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          data_oe_nxt = ~shift[0];
          state_nxt   = BITS;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          state_nxt = ERR;
        end
      end
      BITS: begin
        ps2_data_oe = data_oe_r;
        if (fe) begin
          if (bit_cnt == PS2_LAST_BIT) begin
            state_nxt = data_sync ? ERR : WAIT_IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            data_oe_nxt = ~shift[1];
            shift_nxt   = {1'b1, shift[9:1]};
          end
        end else if (cnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
          state_nxt = ERR;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          tx_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        tx_err    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host while a scoreboard holds the expected line bits and frame outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int REQ  = 10;
  localparam int ST   = 500;
  localparam int FT   = 3000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_line, ps2_data_line;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit         exp_bits[$];
  logic [1:0] exp_res[$];

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .START_TIMEOUT  (ST),
    .FRAME_TIMEOUT  (FT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk_async  (ps2_clk_line),
    .ps2_data_async (ps2_data_line),
    .ps2_clk_oe     (ps2_clk_oe),
    .ps2_data_oe    (ps2_data_oe),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_done        (tx_done),
    .tx_err         (tx_err),
    .busy           (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic [1:0] res);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
    exp_res.push_back(res);
  endtask

  task automatic send(input logic [7:0] b, input bit hold, input logic [1:0] res);
    push_frame(b, res);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Device side: waits out inhibit/request, then generates falling edges,
  // checking the data line while the clock is high before each edge.
  task automatic dev_frame(input int edges, input bit ack);
    int   n = 0;
    int   n_inh = 0;
    int   n_req = 0;
    logic bv;
    while (ps2_clk_oe !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 2 * (INH + REQ)) begin
      if (ps2_data_oe) n_req++;
      else n_inh++;
      tick(1);
      n++;
    end
    check("inhibit_cycles", n_inh, INH);
    check("req_cycles", n_req, REQ);
    tick(HALF);
    for (int e = 1; e <= edges; e++) begin
      if (exp_bits.size() > 0) begin
        bv = exp_bits.pop_front();
        check($sformatf("frame_bit%0d", e - 1), ps2_data_line, bv);
      end
      if (e == 11 && ack) begin
        dev_data = 1'b0;
        tick(4);
      end
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(HALF);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic score(input string tag, input int d0, input int e0);
    logic [1:0] exp;
    if (exp_res.size() == 0) begin
      check({tag, "_scoreboard"}, 0, 1);
    end else begin
      exp = exp_res.pop_front();
      check({tag, "_done_pulses"}, done_cnt - d0, exp[1]);
      check({tag, "_err_pulses"}, err_cnt - e0, exp[0]);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] b, input bit ack, input logic [1:0] res);
    int d0 = done_cnt;
    int e0 = err_cnt;
    send(b, 1'b0, res);
    dev_frame(11, ack);
    wait_outcome(d0, e0);
    score(tag, d0, e0);
    tick(1);
    check({tag, "_ready_after"}, tx_ready, 1);
    tick(3);
    check({tag, "_single_pulse"}, (done_cnt - d0) + (err_cnt - e0), 1);
  endtask

  initial begin
    int d0, e0, n;
    tick(3);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    run("set_leds", PS2_CMD_SET_LEDS, 1'b1, 2'b10);
    run("enable", PS2_CMD_ENABLE, 1'b1, 2'b10);
    run("byte_01", 8'h01, 1'b1, 2'b10);

    // Device never clocks: error exactly START_TIMEOUT cycles after release.
    d0 = done_cnt;
    e0 = err_cnt;
    exp_res.push_back(2'b01);
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 2 * (INH + REQ)) begin
      tick(1);
      n++;
    end
    n = 0;
    while (tx_err !== 1'b1 && n < ST + 100) begin
      tick(1);
      n++;
    end
    check("start_timeout_cycles", n, ST);
    check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    score("start_timeout", d0, e0);
    tick(1);
    check("timeout_ready_after", tx_ready, 1);

    run("no_ack", 8'h3C, 1'b0, 2'b01);

    // Reset after the 5th falling edge.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5, 1'b0, 2'b00);
    dev_frame(4, 1'b0);
    dev_clk = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("midrst_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tx_ready, 1);
    rst = 1'b0;
    dev_clk = 1'b1;
    exp_bits.delete();
    tick(20);
    score("midrst", d0, e0);

    run("reset_cmd", PS2_CMD_RESET, 1'b1, 2'b10);

    // tx_valid held: one frame, then a second only once tx_ready returns.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00, 1'b1, 2'b10);
    dev_frame(11, 1'b1);
    wait_outcome(d0, e0);
    score("hold_first", d0, e0);
    tick(1);
    check("hold_rearm_ready", tx_ready, 1);
    check("hold_rearm_clk_oe", ps2_clk_oe, 0);
    tick(1);
    check("hold_second_start", ps2_clk_oe, 1);
    tx_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(8'h00, 2'b10);
    dev_frame(11, 1'b1);
    wait_outcome(d0, e0);
    score("hold_second", d0, e0);
    tick(5);
    check("hold_final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
